// File: rtl/program_memory_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the program loader.
// The loader uses the slave view; the byte source / memory side uses the master view.
interface program_memory_loader_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [7:0]            Byte_i;
  logic                  Byte_Valid_i;
  logic                  Byte_Ready_o;
  logic                  Mem_Wr_En_o;
  logic [DATA_WIDTH-1:0] Mem_Address_o;
  logic [DATA_WIDTH-1:0] Mem_Data_o;

  modport master (
    output Byte_i, Byte_Valid_i,
    input  Byte_Ready_o, Mem_Wr_En_o, Mem_Address_o, Mem_Data_o
  );

  modport slave (
    input  Byte_i, Byte_Valid_i,
    output Byte_Ready_o, Mem_Wr_En_o, Mem_Address_o, Mem_Data_o
  );
endinterface

// File: rtl/program_memory_loader.sv
// Program loader: byte stream -> little-endian 32-bit words -> instruction RAM, core held meanwhile.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte checked in the CHK state.
module program_memory_loader #(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  program_memory_loader_if.slave bus,
  output logic                  Cpu_Hold_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic [15:0]           Words_Loaded_o
);

  localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t                state, next_state;
  logic [1:0]            byte_cnt;
  logic [DATA_WIDTH-9:0] shift_buf;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [15:0]           len_q;
  logic [15:0]           index;
  logic [15:0]           words_q;
  logic                  error_q;
  logic                  ready, wr_en, busy, done;
  logic                  accept, last_byte, len_zero, len_bad, last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
  assign asm_word  = {bus.Byte_i, shift_buf};
  assign accept    = bus.Byte_Valid_i & ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign len_zero  = (asm_word == '0);
  assign len_bad   = (|asm_word[DATA_WIDTH-1:16]) || (asm_word[15:0] > DEPTH16);
  assign last_word = ((index + 16'd1) == len_q);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (Start_i) next_state = S_LEN;
      S_LEN: if (last_byte) begin
        if (len_zero)
`ifdef LOADER_CHECKSUM_EN
          next_state = S_CHK;
`else
          next_state = S_DONE;
`endif
        else if (len_bad) next_state = S_DONE;
        else              next_state = S_DATA;
      end
      S_DATA: if (last_byte) next_state = S_WRITE;
      S_WRITE: begin
        if (last_word)
`ifdef LOADER_CHECKSUM_EN
          next_state = S_CHK;
`else
          next_state = S_DONE;
`endif
        else
          next_state = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (accept) next_state = S_DONE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    wr_en = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      S_IDLE:         busy  = 1'b0;
      S_LEN, S_DATA:  ready = 1'b1;
      S_WRITE:        wr_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:          ready = 1'b1;
`endif
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default:        busy  = 1'b0;
    endcase
  end

  assign bus.Byte_Ready_o = ready;
  assign bus.Mem_Wr_En_o  = wr_en;
  assign Busy_o           = busy;
  assign Cpu_Hold_o       = busy;
  assign Done_o           = done;
  assign Error_o          = error_q;
  assign Words_Loaded_o   = words_q;

  // Partial-word bytes need no reset: byte_cnt restarting at 0 discards them.
  always_ff @(posedge clk) begin
    if (accept) shift_buf <= asm_word[DATA_WIDTH-1:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt          <= 2'd0;
      len_q             <= 16'd0;
      index             <= 16'd0;
      words_q           <= 16'd0;
      error_q           <= 1'b0;
      bus.Mem_Address_o <= '0;
      bus.Mem_Data_o    <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk               <= 8'd0;
`endif
    end else begin
      if (accept) byte_cnt <= byte_cnt + 2'd1;
      case (state)
        S_IDLE, S_DONE: if (Start_i) begin
          byte_cnt <= 2'd0;
          index    <= 16'd0;
          words_q  <= 16'd0;
          error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          chk      <= 8'd0;
`endif
        end
        S_LEN: if (last_byte) begin
          len_q <= asm_word[15:0];
          if (len_bad) error_q <= 1'b1;
        end
        S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (accept) chk <= chk ^ bus.Byte_i;
`endif
          if (last_byte) begin
            bus.Mem_Address_o <= BASE_ADDR + DATA_WIDTH'({index, 2'b00});
            bus.Mem_Data_o    <= asm_word;
          end
        end
        S_WRITE: begin
          index   <= index + 16'd1;
          words_q <= words_q + 16'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: if (accept && (bus.Byte_i != chk)) error_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Randomized self-checking bench for program_memory_loader; expected words, addresses and
// status come from a byte-level model of the load protocol kept in the bench.
module tb_program_memory_loader;
  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold, busy, done, error;
  logic [15:0] words;

  program_memory_loader_if #(.DATA_WIDTH(32)) bus ();

  program_memory_loader #(
    .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset(reset), .Start_i(start), .bus(bus),
    .Cpu_Hold_o(hold), .Busy_o(busy), .Done_o(done), .Error_o(error),
    .Words_Loaded_o(words)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, long_strobes = 0, last_wr_cyc = -1, done_rise_cyc = -1;
  int late_cnt = 0, timeouts = 0, hold_drop = 0;
  logic prev_wr = 1'b0, prev_done = 1'b0;
  logic [31:0] got_addr[$], got_data[$], exp_data[$];
  logic [7:0]  fixed_q[$];

  always @(posedge clk) cyc++;

  // Write-port monitor: records every strobe and flags strobes longer than one cycle.
  always @(negedge clk) begin
    if (bus.Mem_Wr_En_o) begin
      got_addr.push_back(bus.Mem_Address_o);
      got_data.push_back(bus.Mem_Data_o);
      if (prev_wr) long_strobes++;
      last_wr_cyc = cyc;
    end
    prev_wr = bus.Mem_Wr_En_o;
    if (done && !prev_done) done_rise_cyc = cyc;
    prev_done = done;
  end

  task automatic gap_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    bus.Byte_i       = b;
    bus.Byte_Valid_i = 1'b1;
    while (!bus.Byte_Ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) timeouts++;
    if (!hold) hold_drop++;
    @(negedge clk);
    bus.Byte_Valid_i = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  // poke: data byte number before which Start_i is pulsed (-1 = never).
  task automatic do_load(input logic [31:0] len, input int nwords, input int gap_mode,
                         input logic [7:0] chk_flip, input int poke);
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] w;
    logic        ovf;
    int          k;
    x   = 8'h00;
    ovf = (len[31:16] != 16'd0) || (len[15:0] > 16'(DEPTH));
    exp_data.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
    for (int n = 0; n < nwords; n++) begin
      w = 32'd0;
      for (int i = 0; i < 4; i++) begin
        b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
        w[8*i +: 8] = b;
        x = x ^ b;
        if (gap_mode == 1) gap_cycles(1);
        else if (gap_mode == 2) gap_cycles($urandom_range(0, 2));
        if (n*4 + i == poke) pulse_start();
        send_byte(b);
      end
      if (!bus.Mem_Wr_En_o) late_cnt++;
      exp_data.push_back(w);
    end
    if (CHK_EN && !ovf) send_byte(x ^ chk_flip);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done) timeouts++;
    gap_cycles(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({hold, busy, done, error, bus.Byte_Ready_o, bus.Mem_Wr_En_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {hold, busy, done, error, bus.Byte_Ready_o, bus.Mem_Wr_En_o});
    end
    total++;
    if (words !== 16'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", words); end
    total++;
    if (bus.Mem_Address_o !== 32'd0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", bus.Mem_Address_o);
    end
    total++;
    if (bus.Mem_Data_o !== 32'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", bus.Mem_Data_o);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int base = got_addr.size();
    int t0 = timeouts;
    fixed_q = '{8'h13, 8'h05, 8'hA0, 8'h00};
    do_load(32'd1, 1, 0, 8'h00, -1);
    total++;
    if (got_addr.size() - base != 1) begin
      bad++; $display("FAIL single_count got=%0d want=1", got_addr.size() - base);
    end else begin
      total++;
      if (got_addr[base] !== BASE) begin
        bad++; $display("FAIL single_addr got=%h want=%h", got_addr[base], BASE);
      end
      total++;
      if (got_data[base] !== 32'h00A0_0513) begin
        bad++; $display("FAIL single_data got=%h want=00a00513", got_data[base]);
      end
    end
    total++;
    if ({done, error, hold} !== 3'b100) begin
      bad++; $display("FAIL single_status got=%b want=100", {done, error, hold});
    end
    total++;
    if (words !== 16'd1) begin bad++; $display("FAIL single_words got=%0d want=1", words); end
    total++;
    if (done_rise_cyc - last_wr_cyc != 1) begin
      bad++; $display("FAIL single_done_lat got=%0d want=1", done_rise_cyc - last_wr_cyc);
    end
    total++;
    if (late_cnt != 0 || timeouts != t0) begin
      bad++; $display("FAIL single_timing got=%0d/%0d want=0/%0d", late_cnt, timeouts, t0);
    end
  endtask

  task automatic test_toggle();
    int base = got_addr.size();
    int h0 = hold_drop, l0 = long_strobes, t0 = timeouts, lc0 = late_cnt;
    do_load(32'd3, 3, 1, 8'h00, -1);
    total++;
    if (got_addr.size() - base != 3) begin
      bad++; $display("FAIL toggle_count got=%0d want=3", got_addr.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_addr[base+i] !== BASE + 32'(4*i) || got_data[base+i] !== exp_data[i]) begin
          bad++;
          $display("FAIL toggle_word%0d got=%h:%h want=%h:%h", i, got_addr[base+i],
                   got_data[base+i], BASE + 32'(4*i), exp_data[i]);
        end
      end
    end
    total++;
    if (long_strobes != l0 || late_cnt != lc0) begin
      bad++; $display("FAIL toggle_strobe got=%0d/%0d want=%0d/%0d", long_strobes, late_cnt, l0, lc0);
    end
    total++;
    if (hold_drop != h0) begin bad++; $display("FAIL toggle_hold got=%0d want=%0d", hold_drop, h0); end
    total++;
    if ({done, error, hold} !== 3'b100 || words !== 16'd3 || timeouts != t0) begin
      bad++; $display("FAIL toggle_status got=%b/%0d want=100/3", {done, error, hold}, words);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] lens[3] = '{32'd33, 32'h0001_0001, 32'd0};
    logic        errs[3] = '{1'b1, 1'b1, 1'b0};
    for (int j = 0; j < 3; j++) begin
      int base = got_addr.size();
      int t0 = timeouts;
      do_load(lens[j], 0, 0, 8'h00, -1);
      total++;
      if (got_addr.size() != base) begin
        bad++; $display("FAIL ovf%0d_writes got=%0d want=0", j, got_addr.size() - base);
      end
      total++;
      if ({done, error, hold} !== {1'b1, errs[j], 1'b0} || words !== 16'd0 || timeouts != t0) begin
        bad++;
        $display("FAIL ovf%0d_status got=%b/%0d want=%b/0", j, {done, error, hold}, words,
                 {1'b1, errs[j], 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    int base = got_addr.size();
    int t0 = timeouts;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd2 : 8'd0);
    send_byte(8'hAA);
    send_byte(8'h55);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({hold, busy, done, error, bus.Byte_Ready_o, bus.Mem_Wr_En_o} !== 6'b0 ||
        words !== 16'd0 || bus.Mem_Address_o !== 32'd0 || bus.Mem_Data_o !== 32'd0) begin
      bad++;
      $display("FAIL midreset_outputs got=%b/%0d/%h/%h want=0",
               {hold, busy, done, error, bus.Byte_Ready_o, bus.Mem_Wr_En_o}, words,
               bus.Mem_Address_o, bus.Mem_Data_o);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (got_addr.size() != base) begin
      bad++; $display("FAIL midreset_nowrite got=%0d want=0", got_addr.size() - base);
    end
    do_load(32'd2, 2, 2, 8'h00, -1);
    total++;
    if (got_addr.size() - base != 2) begin
      bad++; $display("FAIL midreset_reload_count got=%0d want=2", got_addr.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (got_addr[base+i] !== BASE + 32'(4*i) || got_data[base+i] !== exp_data[i]) begin
          bad++;
          $display("FAIL midreset_word%0d got=%h:%h want=%h:%h", i, got_addr[base+i],
                   got_data[base+i], BASE + 32'(4*i), exp_data[i]);
        end
      end
    end
    total++;
    if (timeouts != t0) begin bad++; $display("FAIL midreset_timeout got=%0d want=%0d", timeouts, t0); end
  endtask

  task automatic test_start_ignored();
    int pokes[2] = '{2, 4};
    for (int j = 0; j < 2; j++) begin
      int base = got_addr.size();
      int t0 = timeouts;
      do_load(32'd3, 3, 0, 8'h00, pokes[j]);
      total++;
      if (got_addr.size() - base != 3 || timeouts != t0) begin
        bad++; $display("FAIL startign%0d_count got=%0d want=3", j, got_addr.size() - base);
      end else begin
        for (int i = 0; i < 3; i++) begin
          total++;
          if (got_addr[base+i] !== BASE + 32'(4*i) || got_data[base+i] !== exp_data[i]) begin
            bad++;
            $display("FAIL startign%0d_word%0d got=%h:%h want=%h:%h", j, i, got_addr[base+i],
                     got_data[base+i], BASE + 32'(4*i), exp_data[i]);
          end
        end
      end
      total++;
      if ({done, error} !== 2'b10 || words !== 16'd3) begin
        bad++; $display("FAIL startign%0d_status got=%b/%0d want=10/3", j, {done, error}, words);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
      int base = got_addr.size();
      int errs = 0;
      int t0 = timeouts;
      do_load(32'(n), n, 2, 8'h00, -1);
      total++;
      if (got_addr.size() - base != n || timeouts != t0) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, got_addr.size() - base, n);
      end else begin
        for (int i = 0; i < n; i++)
          if (got_addr[base+i] !== BASE + 32'(4*i) || got_data[base+i] !== exp_data[i]) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL rand%0d_words got=%0d_bad want=0", it, errs); end
      end
      total++;
      if ({done, error, hold} !== 3'b100 || words !== 16'(n)) begin
        bad++; $display("FAIL rand%0d_status got=%b/%0d want=100/%0d", it, {done, error, hold}, words, n);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] flips[2] = '{8'h00, 8'h01};
    for (int j = 0; j < 2; j++) begin
      int base = got_addr.size();
      fixed_q = '{8'h01, 8'h02, 8'h04, 8'h08};
      do_load(32'd1, 1, 0, flips[j], -1);
      total++;
      if (got_addr.size() - base != 1) begin
        bad++; $display("FAIL chk%0d_count got=%0d want=1", j, got_addr.size() - base);
      end else begin
        total++;
        if (got_data[base] !== 32'h0804_0201) begin
          bad++; $display("FAIL chk%0d_data got=%h want=08040201", j, got_data[base]);
        end
      end
      total++;
      if ({done, error} !== {1'b1, j == 1}) begin
        bad++; $display("FAIL chk%0d_status got=%b want=%b", j, {done, error}, {1'b1, j == 1});
      end
    end
  endtask
`endif

  initial begin
    bus.Byte_i       = 8'h00;
    bus.Byte_Valid_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_toggle();
    test_overflow();
    test_reset_mid();
    test_start_ignored();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
